addr_channel_demux: RTL and testbench

Master-side address-channel router for the crossbar. It accepts one AXI address channel (AR or AW) from a master and decodes the address into a destination slave index through the existing address decoder. It registers the request and presents it on exactly one of `slaves` slave-side address channels. It also enforces in-order response safety: it never switches destination slave while transactions to the previous slave are still outstanding.

---
 rtl/xbar_pkg.sv | 25 ++
 rtl/addr_decoder.sv | 30 +++
 rtl/addr_channel_demux.sv | 131 +++++++++++++
 tb/tb_addr_channel_demux.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar types: burst encoding, field widths and the address-channel payload.
// No logic; types and constants only.
// Not applicable (no handshake in a package).
package xbar_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int ID_WIDTH   = 4;
  localparam int LEN_WIDTH  = 8;
  localparam int SIZE_WIDTH = 3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]   id;
    logic [LEN_WIDTH-1:0]  len;
    logic [SIZE_WIDTH-1:0] size;
    burst_e                burst;
  } addr_payload_t;

endpackage

// File: rtl/addr_decoder.sv
// Address decoder: maps an address onto a slave index using inclusive base/end ranges.
// Latency: purely combinational, zero cycles.
// No flow control; unmapped addresses fall back to slave 0.
module addr_decoder #(
  parameter int ADDR_WIDTH = 32,
  parameter int slaves     = 2,
  parameter logic [slaves-1:0][ADDR_WIDTH-1:0] address_map_base = {32'h1000_0000, 32'h0000_0000},
  parameter logic [slaves-1:0][ADDR_WIDTH-1:0] address_map_end  = {32'h1fff_ffff, 32'h0fff_ffff}
) (
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic [$clog2(slaves)-1:0] o_dest
);

  localparam int SLV_W = $clog2(slaves);

  logic w_hit;

  // First (lowest-index) matching range wins; no match leaves the default slave 0.
  always_comb begin
    o_dest = '0;
    w_hit  = 1'b0;
    for (int i = 0; i < slaves; i++) begin
      if (!w_hit && (i_addr >= address_map_base[i]) && (i_addr <= address_map_end[i])) begin
        o_dest = SLV_W'(i);
        w_hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addr_channel_demux.sv
// Routes one master address channel to one of N slave channels through a one-entry register slice.
// Latency: s_valid rises one cycle after the master handshake; full throughput to the same slave.
// Master stalls while the slice is held, on a slave switch with traffic outstanding, or at the outstanding limit.
module addr_channel_demux
  import xbar_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int slaves          = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [slaves-1:0][ADDR_WIDTH-1:0] address_map_base = {32'h1000_0000, 32'h0000_0000},
  parameter logic [slaves-1:0][ADDR_WIDTH-1:0] address_map_end  = {32'h1fff_ffff, 32'h0fff_ffff}
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETn,
  input  logic [ADDR_WIDTH-1:0]                    m_addr,
  input  logic [ID_WIDTH-1:0]                      m_id,
  input  logic [LEN_WIDTH-1:0]                     m_len,
  input  logic [SIZE_WIDTH-1:0]                    m_size,
  input  logic [1:0]                               m_burst,
  input  logic                                     m_valid,
  output logic                                     m_ready,
  output logic [ADDR_WIDTH-1:0]                    s_addr,
  output logic [ID_WIDTH-1:0]                      s_id,
  output logic [LEN_WIDTH-1:0]                     s_len,
  output logic [SIZE_WIDTH-1:0]                    s_size,
  output logic [1:0]                               s_burst,
  output logic [slaves-1:0]                        s_valid,
  input  logic [slaves-1:0]                        s_ready,
  input  logic                                     resp_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
  output logic [$clog2(slaves)-1:0]                cur_slave
);

  localparam int SLV_W = $clog2(slaves);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e                r_state;
  logic [slaves-1:0]     r_s_valid;
  logic [SLV_W-1:0]      r_sel;
  logic [SLV_W-1:0]      r_cur_slave;
  logic [OUT_W-1:0]      r_outstanding;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [SIZE_WIDTH-1:0] r_size;
  burst_e                r_burst;

  logic [SLV_W-1:0]      w_dest;
  logic                  w_s_fire;
  logic                  w_same_or_empty;
  logic                  w_below_limit;
  logic                  w_m_ready;
  logic                  w_m_hs;
  logic                  w_dec;

  addr_decoder #(
    .ADDR_WIDTH       (ADDR_WIDTH),
    .slaves           (slaves),
    .address_map_base (address_map_base),
    .address_map_end  (address_map_end)
  ) u_addr_decoder (
    .i_addr (m_addr),
    .o_dest (w_dest)
  );

  // Acceptance: slice free (or draining this cycle), no slave switch while responses are pending,
  // and room in the outstanding budget. Gated by reset so the master sees no ready during reset.
  assign w_s_fire        = (r_state == ST_HOLD) && s_ready[r_sel];
  assign w_same_or_empty = (r_outstanding == '0) || (w_dest == r_cur_slave);
  assign w_below_limit   = (r_outstanding < OUT_W'(MAX_OUTSTANDING));
  assign w_m_ready       = ARESETn && ((r_state == ST_IDLE) || w_s_fire) && w_same_or_empty && w_below_limit;
  assign w_m_hs          = m_valid && w_m_ready;
  // A completion with nothing outstanding is ignored so the counter never wraps.
  assign w_dec           = resp_done && (r_outstanding != '0);

  // Output slice FSM: load on master handshake, release on slave handshake, hold otherwise.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= ST_IDLE;
      r_s_valid   <= '0;
      r_sel       <= '0;
      r_cur_slave <= '0;
      r_addr      <= '0;
      r_id        <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= BURST_FIXED;
    end else if (w_m_hs) begin
      r_state     <= ST_HOLD;
      r_s_valid   <= slaves'(1) << w_dest;
      r_sel       <= w_dest;
      r_cur_slave <= w_dest;
      r_addr      <= m_addr;
      r_id        <= m_id;
      r_len       <= m_len;
      r_size      <= m_size;
      r_burst     <= burst_e'(m_burst);
    end else if (w_s_fire) begin
      r_state     <= ST_IDLE;
      r_s_valid   <= '0;
    end
  end

  // Outstanding tracker: +1 per accepted request, -1 per completed transaction.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_outstanding <= '0;
    end else if (w_m_hs && !w_dec) begin
      r_outstanding <= r_outstanding + OUT_W'(1);
    end else if (!w_m_hs && w_dec) begin
      r_outstanding <= r_outstanding - OUT_W'(1);
    end
  end

  assign m_ready     = w_m_ready;
  assign s_valid     = r_s_valid;
  assign s_addr      = r_addr;
  assign s_id        = r_id;
  assign s_len       = r_len;
  assign s_size      = r_size;
  assign s_burst     = r_burst;
  assign outstanding = r_outstanding;
  assign cur_slave   = r_cur_slave;

endmodule

// File: tb/tb_addr_channel_demux.sv
module tb_addr_channel_demux;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] m_addr;
  logic [3:0]  m_id;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] s_addr;
  logic [3:0]  s_id;
  logic [7:0]  s_len;
  logic [2:0]  s_size;
  logic [1:0]  s_burst;
  logic [1:0]  s_valid;
  logic [1:0]  s_ready;
  logic        resp_done;
  logic [2:0]  outstanding;
  logic        cur_slave;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  addr_channel_demux dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .m_addr      (m_addr),
    .m_id        (m_id),
    .m_len       (m_len),
    .m_size      (m_size),
    .m_burst     (m_burst),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .s_addr      (s_addr),
    .s_id        (s_id),
    .s_len       (s_len),
    .s_size      (s_size),
    .s_burst     (s_burst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .resp_done   (resp_done),
    .outstanding (outstanding),
    .cur_slave   (cur_slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESETn   = 1'b0;
    m_addr    = '0;
    m_id      = '0;
    m_len     = '0;
    m_size    = '0;
    m_burst   = '0;
    m_valid   = 1'b0;
    s_ready   = 2'b11;
    resp_done = 1'b0;

    // Reset held for 3 cycles
    repeat (3) @(posedge ACLK);
    #2;
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_cur_slave", 32'(cur_slave), 32'd0);
    chk("rst_s_addr", s_addr, 32'h0);
    #1 ARESETn = 1'b1;
    #1;
    chk("rel_m_ready", 32'(m_ready), 32'd1);

    // Single route to slave 1
    cyc();
    m_addr = 32'h1000_0040; m_id = 4'd5; m_len = 8'd3; m_size = 3'd2; m_burst = 2'd1;
    m_valid = 1'b1;
    #1 chk("single_m_ready", 32'(m_ready), 32'd1);
    cyc();
    m_valid = 1'b0;
    #1;
    chk("single_s_valid", 32'(s_valid), 32'b10);
    chk("single_s_addr", s_addr, 32'h1000_0040);
    chk("single_s_id", 32'(s_id), 32'd5);
    chk("single_s_len", 32'(s_len), 32'd3);
    chk("single_s_size", 32'(s_size), 32'd2);
    chk("single_s_burst", 32'(s_burst), 32'd1);
    chk("single_outstanding", 32'(outstanding), 32'd1);
    chk("single_cur_slave", 32'(cur_slave), 32'd1);
    cyc();
    resp_done = 1'b1;
    #1 chk("single_drained", 32'(s_valid), 32'd0);
    cyc();
    resp_done = 1'b0;
    #1 chk("single_out_zero", 32'(outstanding), 32'd0);

    // Backpressure on slave 0
    s_ready = 2'b10;
    m_addr  = 32'h0000_0100;
    m_valid = 1'b1;
    #1 chk("bp_accept", 32'(m_ready), 32'd1);
    cyc();
    m_addr = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_s_valid", 32'(s_valid), 32'b01);
      chk("bp_s_addr", s_addr, 32'h0000_0100);
      chk("bp_m_ready", 32'(m_ready), 32'd0);
      cyc();
    end
    s_ready = 2'b11;
    #1 chk("bp_release_m_ready", 32'(m_ready), 32'd1);
    cyc();
    m_valid = 1'b0;
    #1;
    chk("bp_next_s_addr", s_addr, 32'h0000_0200);
    chk("bp_outstanding", 32'(outstanding), 32'd2);
    cyc();

    // Slave switch with 2 outstanding to slave 0
    m_addr  = 32'h1000_0000;
    m_valid = 1'b1;
    #1 chk("sw_stall0", 32'(m_ready), 32'd0);
    cyc();
    resp_done = 1'b1;
    #1 chk("sw_stall1", 32'(m_ready), 32'd0);
    cyc();
    #1;
    chk("sw_out1", 32'(outstanding), 32'd1);
    chk("sw_stall2", 32'(m_ready), 32'd0);
    cyc();
    resp_done = 1'b0;
    #1;
    chk("sw_out0", 32'(outstanding), 32'd0);
    chk("sw_accept", 32'(m_ready), 32'd1);
    cyc();
    m_valid = 1'b0;
    #1;
    chk("sw_s_valid", 32'(s_valid), 32'b10);
    chk("sw_cur_slave", 32'(cur_slave), 32'd1);
    chk("sw_outstanding", 32'(outstanding), 32'd1);
    cyc();
    resp_done = 1'b1;
    cyc();
    resp_done = 1'b0;
    #1 chk("sw_cleanup", 32'(outstanding), 32'd0);

    // Outstanding limit: 4 back-to-back to slave 0, fifth stalls
    m_addr  = 32'h0000_0000;
    m_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("lim_accept", 32'(m_ready), 32'd1);
      cyc();
    end
    #1;
    chk("lim_stall", 32'(m_ready), 32'd0);
    chk("lim_out4", 32'(outstanding), 32'd4);
    cyc();
    resp_done = 1'b1;
    #1 chk("lim_stall_with_done", 32'(m_ready), 32'd0);
    cyc();
    resp_done = 1'b0;
    #1;
    chk("lim_resume", 32'(m_ready), 32'd1);
    chk("lim_out3", 32'(outstanding), 32'd3);
    cyc();
    m_valid = 1'b0;
    #1;
    chk("lim_out4_again", 32'(outstanding), 32'd4);
    chk("lim_s_valid", 32'(s_valid), 32'b01);
    cyc();

    // Simultaneous handshake and completion
    resp_done = 1'b1;
    cyc(); cyc(); cyc();
    resp_done = 1'b0;
    #1 chk("sim_out1", 32'(outstanding), 32'd1);
    m_valid = 1'b1;
    cyc();
    resp_done = 1'b1;
    #1;
    chk("sim_m_ready", 32'(m_ready), 32'd1);
    chk("sim_out2_before", 32'(outstanding), 32'd2);
    cyc();
    m_valid   = 1'b0;
    resp_done = 1'b0;
    #1 chk("sim_out2_after", 32'(outstanding), 32'd2);
    resp_done = 1'b1;
    cyc(); cyc();
    #1 chk("sim_out0", 32'(outstanding), 32'd0);
    cyc();
    resp_done = 1'b0;
    #1 chk("spurious_done", 32'(outstanding), 32'd0);

    // Unmapped address defaults to slave 0, then reset while holding
    s_ready = 2'b00;
    m_addr  = 32'h2000_0000;
    m_valid = 1'b1;
    cyc();
    m_valid = 1'b0;
    #1;
    chk("unmapped_s_valid", 32'(s_valid), 32'b01);
    chk("unmapped_cur_slave", 32'(cur_slave), 32'd0);
    chk("unmapped_outstanding", 32'(outstanding), 32'd1);
    ARESETn = 1'b0;
    #1;
    chk("midrst_s_valid", 32'(s_valid), 32'd0);
    chk("midrst_outstanding", 32'(outstanding), 32'd0);
    chk("midrst_m_ready", 32'(m_ready), 32'd0);
    chk("midrst_s_addr", s_addr, 32'h0);
    cyc();
    ARESETn = 1'b1;
    #1;
    chk("midrst_rel_m_ready", 32'(m_ready), 32'd1);
    chk("midrst_rel_s_valid", 32'(s_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
